// File: rtl/porta_uart_tx_pkg.sv
// porta_uart_tx_pkg
//   Shared definitions for the port-A serial transmit stage: FSM state
//   encoding, frame geometry and default parameter values.
package porta_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CLK_DIV    = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // One start bit, DATA_WIDTH data bits, one stop bit.
  localparam int UART_FRAME_BITS = DEFAULT_DATA_WIDTH + 2;

  function automatic int uart_frame_bits(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/porta_uart_tx_byte_fifo.sv
// porta_uart_tx_byte_fifo
//   Synchronous FIFO used to buffer bytes in front of the serializer.
//   Kept generic so a future receive path can reuse it.
//   A push is accepted when not full, or when a pop happens on the same
//   edge (the freed slot is reused, so no data is lost).
// Ports:
//   CLK    in   clock, rising edge
//   nRST   in   asynchronous active-low reset
//   push   in   write request
//   pop    in   read request (ignored while empty)
//   din    in   write data
//   head   out  oldest entry (valid while !empty)
//   full   out  count == DEPTH, registered
//   empty  out  count == 0
//   count  out  number of stored entries
//   wr_ok  out  the push on this edge is accepted
module porta_uart_tx_byte_fifo
  import porta_uart_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             wr_ok
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop & (count_r != '0);
  assign push_ok_s = push & (~full_r | pop_ok_s);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage, wrapping pointers (DEPTH is a power of two), count and full flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = (count_r == '0);
  assign count = count_r;
  assign wr_ok = push_ok_s;

endmodule

// File: rtl/porta_uart_tx.sv
// porta_uart_tx
//   Captures every byte written to output port A, buffers it and sends it
//   as an 8N1 frame (start 0, data LSB first, stop 1), CLK_DIV clocks per bit.
//   Back-to-back frames follow each other with no idle gap.
// Ports:
//   CLK      in   clock, rising edge
//   nRST     in   asynchronous active-low reset (aborts any frame)
//   WR_EN    in   port-A write strobe
//   DATA_IN  in   accumulator byte to send
//   CLR_OVR  in   synchronous clear of OVERRUN (a new drop wins)
//   TX       out  serial line, idle high, straight from a flop
//   BUSY     out  FIFO non-empty or frame in progress
//   FULL     out  FIFO holds FIFO_DEPTH bytes
//   OVERRUN  out  sticky: a write was dropped
module porta_uart_tx
  import porta_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  CLR_OVR,
  output logic                  TX,
  output logic                  BUSY,
  output logic                  FULL,
  output logic                  OVERRUN
);

  localparam int DIV_W = 16;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_r;
  logic [DIV_W-1:0]      div_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  tx_r;
  logic                  busy_r;
  logic                  ovr_r;

  logic [DATA_WIDTH-1:0] fifo_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_wr_ok_s;
  logic                  pop_s;
  logic                  fifo_left_s;
  logic                  drop_s;
  logic                  div_last_s;

  porta_uart_tx_byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (WR_EN),
    .pop   (pop_s),
    .din   (DATA_IN),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s),
    .wr_ok (fifo_wr_ok_s)
  );

  assign div_last_s = (div_r == DIV_LAST);

  // Pop request: from IDLE, or on the final STOP cycle for a gapless next frame.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = ~fifo_empty_s;
      ST_STOP: pop_s = div_last_s & ~fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO occupancy after this edge is non-zero; feeds the registered BUSY.
  assign fifo_left_s = fifo_wr_ok_s
                     | (fifo_count_s > CW'(1))
                     | ((fifo_count_s == CW'(1)) & ~pop_s);

  assign drop_s = WR_EN & ~fifo_wr_ok_s;

  // Frame FSM with divider, bit index, shift register and all output flops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= ST_IDLE;
      div_r     <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      // A drop on this edge outranks a clear request.
      if (drop_s) begin
        ovr_r <= 1'b1;
      end else if (CLR_OVR) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r <= ST_START;
            div_r   <= '0;
            shift_r <= fifo_head_s;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= fifo_left_s;
          end
        end
        ST_START: begin
          busy_r <= 1'b1;
          if (div_last_s) begin
            state_r   <= ST_DATA;
            div_r     <= '0;
            bit_idx_r <= '0;
            tx_r      <= shift_r[0];
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_DATA: begin
          busy_r <= 1'b1;
          if (div_last_s) begin
            div_r <= '0;
            if (bit_idx_r == IDX_LAST) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              // Present the next bit from the flop while shifting right.
              bit_idx_r <= bit_idx_r + IDX_W'(1);
              shift_r   <= {1'b0, shift_r[DATA_WIDTH-1:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (div_last_s) begin
            div_r <= '0;
            if (pop_s) begin
              state_r <= ST_START;
              shift_r <= fifo_head_s;
              tx_r    <= 1'b0;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= fifo_left_s;
            end
          end else begin
            div_r  <= div_r + DIV_W'(1);
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          div_r   <= '0;
          tx_r    <= 1'b1;
          busy_r  <= fifo_left_s;
        end
      endcase
    end
  end

  assign TX      = tx_r;
  assign BUSY    = busy_r;
  assign FULL    = fifo_full_s;
  assign OVERRUN = ovr_r;

endmodule
